// File: rtl/axis_frame_pad_pkg.sv
// rtl/axis_frame_pad_pkg.sv - shared state encoding and keep/byte-count helpers for axis_frame_pad
package axis_frame_pad_pkg;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } pad_state_t;

  // Widest tkeep the helpers handle (DATA_WIDTH up to 1024).
  localparam int MAX_KEEP = 128;

  // Number of valid bytes in a word: index of the highest set keep bit + 1.
  function automatic int keep_to_bytes(input logic [MAX_KEEP-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEEP; i++) begin
      if (keep[i]) n = i + 1;
    end
    return n;
  endfunction

  // Keep mask with the low n bits set.
  function automatic logic [MAX_KEEP-1:0] bytes_to_keep(input int n);
    logic [MAX_KEEP-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_frame_pad.sv
// rtl/axis_frame_pad.sv - pads AXI4-Stream frames shorter than MIN_LENGTH bytes with zero bytes
module axis_frame_pad
  import axis_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int MIN_LENGTH  = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int CW = $clog2(MIN_LENGTH + 1);

  pad_state_t            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic [DATA_WIDTH-1:0] data_d;
  logic [KEEP_WIDTH-1:0] keep_d;
  logic                  valid_d;
  logic                  last_d;
  logic [USER_WIDTH-1:0] tuser_d;

  logic load;
  logic accept;
  int   in_bytes;
  int   sum_bytes;
  int   deficit;
  int   room;
  int   remaining;

  assign load          = m_axis_tready || !m_axis_tvalid;
  assign s_axis_tready = load && (state_q == ST_PASS);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    in_bytes  = KEEP_ENABLE ? keep_to_bytes(MAX_KEEP'(s_axis_tkeep)) : KEEP_WIDTH;
    sum_bytes = int'(count_q) + in_bytes;
    deficit   = MIN_LENGTH - sum_bytes;
    room      = KEEP_WIDTH - in_bytes;
    remaining = MIN_LENGTH - int'(count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // PAD is entered only when the short frame's last word cannot hold the whole deficit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: begin
        if (accept && s_axis_tlast && (sum_bytes < MIN_LENGTH) && (deficit > room))
          state_d = ST_PAD;
      end
      ST_PAD: begin
        if (load && (remaining <= KEEP_WIDTH))
          state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_comb begin
    count_d = count_q;
    user_d  = user_q;
    valid_d = m_axis_tvalid;
    data_d  = m_axis_tdata;
    keep_d  = m_axis_tkeep;
    last_d  = m_axis_tlast;
    tuser_d = m_axis_tuser;
    if (load) begin
      valid_d = 1'b0;
      case (state_q)
        ST_PASS: begin
          if (accept) begin
            valid_d = 1'b1;
            data_d  = s_axis_tdata;
            keep_d  = KEEP_ENABLE ? s_axis_tkeep : '1;
            last_d  = s_axis_tlast;
            tuser_d = USER_ENABLE ? s_axis_tuser : '0;
            if (!s_axis_tlast) begin
              count_d = (sum_bytes >= MIN_LENGTH) ? CW'(MIN_LENGTH) : CW'(sum_bytes);
            end else if (sum_bytes >= MIN_LENGTH) begin
              count_d = '0;
            end else begin
              for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (i >= in_bytes) data_d[i*8 +: 8] = 8'h00;
              end
              if (deficit <= room) begin
                keep_d  = KEEP_WIDTH'(bytes_to_keep(in_bytes + deficit));
                count_d = '0;
              end else begin
                // Bad-frame flag rides on the final pad word, not this one.
                keep_d  = '1;
                last_d  = 1'b0;
                tuser_d = '0;
                user_d  = USER_ENABLE ? s_axis_tuser : '0;
                count_d = CW'(int'(count_q) + KEEP_WIDTH);
              end
            end
          end
        end
        ST_PAD: begin
          valid_d = 1'b1;
          data_d  = '0;
          last_d  = 1'b0;
          tuser_d = '0;
          keep_d  = (KEEP_ENABLE && (remaining < KEEP_WIDTH)) ?
                    KEEP_WIDTH'(bytes_to_keep(remaining)) : '1;
          if (remaining <= KEEP_WIDTH) begin
            last_d  = 1'b1;
            tuser_d = user_q;
            count_d = '0;
          end else begin
            count_d = CW'(int'(count_q) + KEEP_WIDTH);
          end
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      user_q        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      count_q       <= count_d;
      user_q        <= user_d;
      m_axis_tdata  <= data_d;
      m_axis_tkeep  <= keep_d;
      m_axis_tvalid <= valid_d;
      m_axis_tlast  <= last_d;
      m_axis_tuser  <= tuser_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_pad.sv
// tb/tb_axis_frame_pad.sv - self-checking bench for axis_frame_pad (64-bit/60-byte and 8-bit/4-byte)
module tb_axis_frame_pad;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast;
  logic [0:0]  s_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [0:0]  m_tuser;

  logic [7:0]  b_s_tdata;
  logic [0:0]  b_s_tkeep;
  logic        b_s_tvalid, b_s_tready, b_s_tlast;
  logic [0:0]  b_s_tuser;
  logic [7:0]  b_m_tdata;
  logic [0:0]  b_m_tkeep;
  logic        b_m_tvalid, b_m_tready, b_m_tlast;
  logic [0:0]  b_m_tuser;

  axis_frame_pad #(.DATA_WIDTH(64), .MIN_LENGTH(60)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  axis_frame_pad #(.DATA_WIDTH(8), .MIN_LENGTH(4)) dut8 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  word_t      in_q[$];
  word_t      exp_q[$];
  word_t      got_q[$];
  logic [7:0] got8[$];
  logic       last8[$];

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_tvalid && m_tready) got_q.push_back('{m_tdata, m_tkeep, m_tlast, m_tuser[0]});
        if (!s_tready) stall_cnt++;
        if (b_m_tvalid && b_m_tready) begin
          got8.push_back(b_m_tdata);
          last8.push_back(b_m_tlast);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  // Reference: output is the input bytes followed by zeros up to max(len, 60), 8 bytes per word.
  task automatic build_frame(input int len, input bit fu);
    logic [7:0] fb[$];
    bit         iu[$];
    int         nin, ol, nout;
    word_t      w, e;
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    nin  = (len + 7) / 8;
    ol   = (len < 60) ? 60 : len;
    nout = (ol + 7) / 8;
    for (int k = 0; k < nin; k++) iu.push_back(bit'($urandom_range(0, 1)));
    for (int k = 0; k < nin; k++) begin
      for (int j = 0; j < 8; j++) begin
        w.data[j*8 +: 8] = (8*k + j < len) ? fb[8*k + j] : 8'($urandom);
        w.keep[j]        = (8*k + j < len);
      end
      w.last = (k == nin - 1);
      w.user = w.last ? fu : iu[k];
      in_q.push_back(w);
    end
    for (int k = 0; k < nout; k++) begin
      for (int j = 0; j < 8; j++) begin
        e.data[j*8 +: 8] = (8*k + j < len) ? fb[8*k + j] : 8'h00;
        e.keep[j]        = (8*k + j < ol);
      end
      e.last = (k == nout - 1);
      e.user = e.last ? fu : ((k < nin - 1) ? iu[k] : 1'b0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_all();
    word_t w;
    int    n;
    while (in_q.size() > 0) begin
      w        = in_q.pop_front();
      s_tdata  = w.data;
      s_tkeep  = w.keep;
      s_tlast  = w.last;
      s_tuser  = w.user;
      s_tvalid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_tready && n < 2000);
      if (!s_tready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_axis_tready stayed %b, required 1", s_tready);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic wait_and_compare(input string name, input int budget);
    int          n;
    int          lim;
    logic [63:0] m;
    word_t       e, g;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      e = exp_q[i];
      g = got_q[i];
      for (int j = 0; j < 8; j++) m[j*8 +: 8] = {8{e.keep[j]}};
      checks++;
      if ({g.keep, g.last, g.user} !== {e.keep, e.last, e.user}) begin
        errors++;
        $display("FAIL %s ctrl word %0d: got keep=%h last=%b user=%b, expected keep=%h last=%b user=%b",
                 name, i, g.keep, g.last, g.user, e.keep, e.last, e.user);
      end
      checks++;
      if ((g.data & m) !== (e.data & m)) begin
        errors++;
        $display("FAIL %s data word %0d: got %h, expected %h (keep %h)", name, i, g.data, e.data, e.keep);
      end
    end
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    in_q.delete();
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    stall_cnt = 0;
  endtask

  task automatic check_stalls(input string name, input int expected);
    checks++;
    if (stall_cnt !== expected) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stall_cnt, expected);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tkeep = 1'b1; b_s_tlast = 1'b0; b_s_tuser = '0;
    b_m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b user=%b keep=%h data=%h, expected all zero",
               m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, expected 1", s_tready);
    end
    checks++;
    if (b_m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_narrow_valid: got %b, expected 0", b_m_tvalid);
    end
    rst = 1'b0;
  endtask

  task automatic test_long_frame();
    start_test();
    build_frame(64, 1'b0);
    send_all();
    wait_and_compare("long64", 200);
    check_stalls("long64", 0);
  endtask

  task automatic test_short_pad();
    start_test();
    build_frame(10, 1'b1);
    send_all();
    wait_and_compare("short10", 200);
    check_stalls("short10", 6);
    if (got_q.size() == 8) begin
      checks++;
      if (got_q[1].keep !== 8'hFF || got_q[1].data[63:16] !== 48'd0 || got_q[1].last !== 1'b0) begin
        errors++;
        $display("FAIL short10 word2: got keep=%h data=%h last=%b, expected keep=ff upper bytes zero last=0",
                 got_q[1].keep, got_q[1].data, got_q[1].last);
      end
      checks++;
      if (got_q[7].keep !== 8'h0F || got_q[7].last !== 1'b1 || got_q[7].user !== 1'b1) begin
        errors++;
        $display("FAIL short10 word8: got keep=%h last=%b user=%b, expected keep=0f last=1 user=1",
                 got_q[7].keep, got_q[7].last, got_q[7].user);
      end
    end
  endtask

  task automatic test_near_min();
    start_test();
    build_frame(58, 1'b1);
    send_all();
    wait_and_compare("len58", 200);
    check_stalls("len58", 0);
    start_test();
    build_frame(60, 1'b1);
    send_all();
    wait_and_compare("len60", 200);
    check_stalls("len60", 0);
  endtask

  task automatic test_random_backpressure();
    start_test();
    for (int f = 0; f < 200; f++) build_frame($urandom_range(1, 100), bit'($urandom_range(0, 1)));
    rand_ready = 1'b1;
    send_all();
    wait_and_compare("random", 30000);
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid_pad();
    start_test();
    build_frame(1, 1'b1);
    send_all();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pad_valid: got %b, expected 0", m_tvalid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_test();
    build_frame(5, 1'b0);
    send_all();
    wait_and_compare("after_reset", 200);
  endtask

  task automatic test_narrow();
    logic [7:0] e8[4];
    int         n;
    e8[0] = 8'hAA; e8[1] = 8'h00; e8[2] = 8'h00; e8[3] = 8'h00;
    @(posedge clk);
    #1;
    got8.delete();
    last8.delete();
    b_s_tdata = 8'hAA; b_s_tkeep = 1'b1; b_s_tlast = 1'b1; b_s_tuser = 1'b0; b_s_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_s_tready && n < 50);
    @(posedge clk);
    #1;
    b_s_tvalid = 1'b0;
    n = 0;
    while (got8.size() < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got8.size() !== 4) begin
      errors++;
      $display("FAIL narrow word_count: got %0d, expected 4", got8.size());
    end
    for (int i = 0; i < 4 && i < got8.size(); i++) begin
      checks++;
      if (got8[i] !== e8[i] || last8[i] !== (i == 3)) begin
        errors++;
        $display("FAIL narrow byte %0d: got %h last=%b, expected %h last=%b", i, got8[i], last8[i], e8[i], (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_short_pad();
    test_near_min();
    test_random_backpressure();
    test_reset_mid_pad();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
